// File: rtl/karatsuba_ctrl.sv
// Sequential 8x8 unsigned multiplier: one Karatsuba level on 4-bit halves, three lookups into an external 5x5 product ROM.
// Optional build macro ZERO_SKIP_EN: a zero operand bypasses the ROM lookups and reports a product of 0.
//
// state  | meaning
// IDLE   | waiting for an operand pair, in_ready high
// LO     | looking up p0 = a0*b0
// HI     | looking up p2 = a1*b1
// MID    | looking up pm = (a1+a0)*(b1+b0), then combining
// DONE   | product valid, waiting for the sink
module karatsuba_ctrl #(
  parameter int ROM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        rom_req,
  output logic [9:0]  rom_addr,
  input  logic [9:0]  rom_data
);

  if (ROM_LATENCY != 0 && ROM_LATENCY != 1) begin : g_bad_latency
    $error("karatsuba_ctrl: ROM_LATENCY must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_MID,
    S_DONE
  } state_t;

  localparam logic CNT_LOAD = (ROM_LATENCY == 1) ? 1'b1 : 1'b0;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [9:0]  p0_q, p0_d;
  logic [9:0]  p2_q, p2_d;
  logic [15:0] prod_q, prod_d;
  logic        cnt_q, cnt_d;
  logic        skip;

  logic [4:0]  sa;
  logic [4:0]  sb;
  logic [15:0] prod_calc;

`ifdef ZERO_SKIP_EN
  logic        skip_q, skip_d;
  assign skip = skip_q;
`else
  assign skip = 1'b0;
`endif

  assign sa = {1'b0, a_q[7:4]} + {1'b0, a_q[3:0]};
  assign sb = {1'b0, b_q[7:4]} + {1'b0, b_q[3:0]};

  // rom_data holds pm while in MID; the middle term is non-negative by construction
  assign prod_calc = ({6'd0, p2_q} << 8)
                   + (({6'd0, rom_data} - {6'd0, p2_q} - {6'd0, p0_q}) << 4)
                   + {6'd0, p0_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    p0_d      = p0_q;
    p2_d      = p2_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
`ifdef ZERO_SKIP_EN
    skip_d    = skip_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rom_req   = 1'b0;
    rom_addr  = 10'd0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = CNT_LOAD;
          state_d = S_LO;
`ifdef ZERO_SKIP_EN
          skip_d  = (in_a == 8'd0) || (in_b == 8'd0);
`endif
        end
      end
      S_LO: begin
        // a skipped operation spends one quiet cycle here so out_valid rises one cycle after accept
        if (skip) begin
          prod_d  = 16'd0;
          state_d = S_DONE;
        end else begin
          rom_req  = 1'b1;
          rom_addr = {1'b0, b_q[3:0], 1'b0, a_q[3:0]};
          if (cnt_q == 1'b0) begin
            p0_d    = rom_data;
            cnt_d   = CNT_LOAD;
            state_d = S_HI;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_HI: begin
        rom_req  = 1'b1;
        rom_addr = {1'b0, b_q[7:4], 1'b0, a_q[7:4]};
        if (cnt_q == 1'b0) begin
          p2_d    = rom_data;
          cnt_d   = CNT_LOAD;
          state_d = S_MID;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MID: begin
        rom_req  = 1'b1;
        rom_addr = {sb, sa};
        if (cnt_q == 1'b0) begin
          prod_d  = prod_calc;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      p0_q    <= 10'd0;
      p2_q    <= 10'd0;
      prod_q  <= 16'd0;
      cnt_q   <= 1'b0;
`ifdef ZERO_SKIP_EN
      skip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p0_q    <= p0_d;
      p2_q    <= p2_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`ifdef ZERO_SKIP_EN
      skip_q  <= skip_d;
`endif
    end
  end

  assign out_product = prod_q;

endmodule

// File: tb/tb_karatsuba_ctrl.sv
// Bench for karatsuba_ctrl: one instance per ROM latency, each with its own ROM model, checked against a scoreboard.
module tb_karatsuba_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  in_a [2];
  logic [7:0]  in_b [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_product [2];
  logic        rom_req [2];
  logic [9:0]  rom_addr [2];
  logic [9:0]  rom_data [2];
  logic [9:0]  rom_reg;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q [$];
  logic [9:0]  addr_q [$];

  karatsuba_ctrl #(.ROM_LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_product(out_product[0]),
    .rom_req(rom_req[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0])
  );

  karatsuba_ctrl #(.ROM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_product(out_product[1]),
    .rom_req(rom_req[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1])
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rom_f(input logic [9:0] ad);
    logic [9:0] x;
    logic [9:0] y;
    x = {5'd0, ad[4:0]};
    y = {5'd0, ad[9:5]};
    return x * y;
  endfunction

  assign rom_data[0] = rom_f(rom_addr[0]);
  always @(posedge clk) rom_reg <= rom_f(rom_addr[1]);
  assign rom_data[1] = rom_reg;

  task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b,
                       input int stall, input string name);
    int cnt;
    int lat;
    logic expect_req;
    logic [15:0] aw, bw, held;
    logic [4:0] sa, sb;
    logic [9:0] lo, hi, mid;
    aw = {8'd0, a};
    bw = {8'd0, b};
    sa = a[7:4] + a[3:0];
    sb = b[7:4] + b[3:0];
    lo = {1'b0, b[3:0], 1'b0, a[3:0]};
    hi = {1'b0, b[7:4], 1'b0, a[7:4]};
    mid = {sb, sa};
`ifdef ZERO_SKIP_EN
    if (a == 8'd0 || b == 8'd0) lat = 1;
    else lat = 3 * (d + 1);
`else
    lat = 3 * (d + 1);
`endif
    cnt = 0;
    while (!in_ready[d] && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    total++;
    if (cnt >= 20) begin
      bad++;
      $display("FAIL %s ready_timeout: in_ready=%0b required=1", name, in_ready[d]);
    end
    in_a[d] = a;
    in_b[d] = b;
    in_valid[d] = 1'b1;
    out_ready[d] = (stall == 0);
    exp_q.push_back(aw * bw);
    if (lat != 1) begin
      for (int j = 0; j <= d; j++) addr_q.push_back(lo);
      for (int j = 0; j <= d; j++) addr_q.push_back(hi);
      for (int j = 0; j <= d; j++) addr_q.push_back(mid);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_a[d] = 8'($urandom);
    in_b[d] = 8'($urandom);
    cnt = 0;
    while (!out_valid[d] && cnt < 40) begin
      expect_req = (addr_q.size() != 0);
      total++;
      if (rom_req[d] !== expect_req || in_ready[d] !== 1'b0) begin
        bad++;
        $display("FAIL %s busy_ctl cyc%0d: rom_req=%0b in_ready=%0b required rom_req=%0b in_ready=0",
                 name, cnt, rom_req[d], in_ready[d], expect_req);
      end
      if (rom_req[d] && expect_req) begin
        total++;
        if (rom_addr[d] !== addr_q[0]) begin
          bad++;
          $display("FAIL %s rom_addr cyc%0d: got=%h required=%h", name, cnt, rom_addr[d], addr_q[0]);
        end
        void'(addr_q.pop_front());
      end
      @(posedge clk); #1;
      cnt++;
    end
    total++;
    if (cnt != lat) begin
      bad++;
      $display("FAIL %s latency: got=%0d required=%0d", name, cnt, lat);
    end
    total++;
    if (addr_q.size() != 0) begin
      bad++;
      $display("FAIL %s lookups_missing: left=%0d required=0", name, addr_q.size());
    end
    addr_q.delete();
    total++;
    if ({rom_req[d], rom_addr[d], in_ready[d]} !== 12'd0) begin
      bad++;
      $display("FAIL %s done_idle_outs: rom_req=%0b rom_addr=%h in_ready=%0b required all 0",
               name, rom_req[d], rom_addr[d], in_ready[d]);
    end
    held = out_product[d];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid[d], out_product[d], in_ready[d]} !== {1'b1, held, 1'b0}) begin
        bad++;
        $display("FAIL %s hold cyc%0d: valid=%0b prod=%h in_ready=%0b required valid=1 prod=%h in_ready=0",
                 name, s, out_valid[d], out_product[d], in_ready[d], held);
      end
    end
    out_ready[d] = 1'b1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard_empty: got=%h", name, out_product[d]);
    end else begin
      if (out_product[d] !== exp_q[0]) begin
        bad++;
        $display("FAIL %s product: got=%h required=%h", name, out_product[d], exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    total++;
    if ({out_valid[d], in_ready[d]} !== 2'b01) begin
      bad++;
      $display("FAIL %s drain: valid=%0b in_ready=%0b required valid=0 in_ready=1",
               name, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({in_ready[d], out_valid[d], out_product[d], rom_req[d], rom_addr[d]} !== {1'b1, 1'b0, 16'd0, 1'b0, 10'd0}) begin
        bad++;
        $display("FAIL reset_vals dut%0d: rdy=%0b vld=%0b prod=%h req=%0b addr=%h required 1 0 0000 0 000",
                 d, in_ready[d], out_valid[d], out_product[d], rom_req[d], rom_addr[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_op(0, 8'h12, 8'h34, 0, "basic_12x34");
    do_op(0, 8'h0F, 8'h0F, 0, "basic_0Fx0F");
  endtask

  task automatic test_max();
    do_op(0, 8'hFF, 8'hFF, 0, "max_lat0");
    do_op(1, 8'hFF, 8'hFF, 0, "max_lat1");
  endtask

  task automatic test_backpressure();
    do_op(0, 8'h0F, 8'hF0, 5, "bp_lat0");
    do_op(1, 8'hF0, 8'h0F, 3, "bp_lat1");
  endtask

  task automatic test_rom_latency1();
    do_op(1, 8'h9A, 8'h5C, 0, "lat1_9Ax5C");
  endtask

  task automatic test_reset_mid();
    in_a[0] = 8'h12;
    in_b[0] = 8'h34;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({rom_req[0], rom_addr[0]} !== {1'b1, 10'h061}) begin
      bad++;
      $display("FAIL rstmid_in_hi: req=%0b addr=%h required req=1 addr=061", rom_req[0], rom_addr[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready[0], out_valid[0], out_product[0], rom_req[0], rom_addr[0]} !== {1'b1, 1'b0, 16'd0, 1'b0, 10'd0}) begin
      bad++;
      $display("FAIL rstmid_vals: rdy=%0b vld=%0b prod=%h req=%0b addr=%h required 1 0 0000 0 000",
               in_ready[0], out_valid[0], out_product[0], rom_req[0], rom_addr[0]);
    end
    exp_q.delete();
    addr_q.delete();
    out_ready[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 8'h03, 8'h05, 0, "after_rst");
  endtask

  task automatic test_zero();
    do_op(0, 8'h00, 8'h7F, 0, "zero_a_lat0");
    do_op(1, 8'h00, 8'h7F, 0, "zero_a_lat1");
    do_op(0, 8'h7F, 8'h00, 2, "zero_b_lat0");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      do_op(i % 2, 8'($urandom), 8'($urandom), i % 3, "b2b_rand");
    end
    do_op(0, 8'h01, 8'hFF, 0, "b2b_01xFF");
    do_op(1, 8'h80, 8'h80, 0, "b2b_80x80");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_a[d] = 8'd0;
      in_b[d] = 8'd0;
      out_ready[d] = 1'b0;
    end
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_rom_latency1();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
